// File: rtl/control_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: opcodes, FSM states,
// ALU operation codes, register-file write-data selects and branch resolution.
package control_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4
    } state_t;

    localparam logic [3:0] ULA_ADD  = 4'd0;
    localparam logic [3:0] ULA_SUB  = 4'd1;
    localparam logic [3:0] ULA_SLL  = 4'd2;
    localparam logic [3:0] ULA_SLT  = 4'd3;
    localparam logic [3:0] ULA_SLTU = 4'd4;
    localparam logic [3:0] ULA_XOR  = 4'd5;
    localparam logic [3:0] ULA_SRL  = 4'd6;
    localparam logic [3:0] ULA_SRA  = 4'd7;
    localparam logic [3:0] ULA_OR   = 4'd8;
    localparam logic [3:0] ULA_AND  = 4'd9;

    localparam logic [1:0] RF_SEL_MEM   = 2'd0;
    localparam logic [1:0] RF_SEL_ALU   = 2'd1;
    localparam logic [1:0] RF_SEL_PC4   = 2'd2;
    localparam logic [1:0] RF_SEL_PCADD = 2'd3;

    // funct3 010/011 never reach EXECUTE (rejected in DECODE), so they resolve not-taken.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic zero,
                                          input logic lt,
                                          input logic ltu);
        logic taken;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/control_unit_mc_if.sv
// Datapath-facing bundle of the control unit: instruction word, ALU flags,
// memory handshake and all datapath control strobes/selects.
interface control_unit_mc_if;

    logic [31:0] instr;
    logic        zero;
    logic        lt;
    logic        ltu;
    logic        mem_ready;

    logic        load_ir;
    logic        load_pc;
    logic        pc_next_sel;
    logic        pc_adder_sel;
    logic        ULA_din2_sel;
    logic [3:0]  ula_op;
    logic [1:0]  RF_din_sel;
    logic        WE_RF;
    logic        WE_MEM;

    modport master (
        input  instr, zero, lt, ltu, mem_ready,
        output load_ir, load_pc, pc_next_sel, pc_adder_sel, ULA_din2_sel,
               ula_op, RF_din_sel, WE_RF, WE_MEM
    );

    modport slave (
        output instr, zero, lt, ltu, mem_ready,
        input  load_ir, load_pc, pc_next_sel, pc_adder_sel, ULA_din2_sel,
               ula_op, RF_din_sel, WE_RF, WE_MEM
    );

endinterface

// File: rtl/ula_decoder.sv
// Combinational ALU operation decode from the latched opcode/funct3/funct7[5].
// Address-generating and non-ALU opcodes resolve to ADD; branches compare with SUB.
module ula_decoder
    import control_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       f7b5,
    output logic [3:0] ula_op
);

    logic is_op;
    logic is_alu;

    always_comb begin
        ula_op = ULA_ADD;
        is_op  = (opcode == OPC_OP);
        is_alu = is_op || (opcode == OPC_OP_IMM);
        if (opcode == OPC_BRANCH) begin
            ula_op = ULA_SUB;
        end else if (is_alu) begin
            case (funct3)
                // Immediate forms have no SUB; bit 30 is part of the immediate there.
                3'b000:  ula_op = (is_op && f7b5) ? ULA_SUB : ULA_ADD;
                3'b001:  ula_op = ULA_SLL;
                3'b010:  ula_op = ULA_SLT;
                3'b011:  ula_op = ULA_SLTU;
                3'b100:  ula_op = ULA_XOR;
                3'b101:  ula_op = f7b5 ? ULA_SRA : ULA_SRL;
                3'b110:  ula_op = ULA_OR;
                default: ula_op = ULA_AND;
            endcase
        end
    end

endmodule

// File: rtl/control_unit_mc.sv
// Multicycle RISC-V control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencing,
// branch resolution from ALU flags, data-memory wait and retired-instruction count.
module control_unit_mc
    import control_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 reset,
    control_unit_mc_if.master    bus,
    output logic                 illegal_instr,
    output logic [2:0]           state_o,
    output logic [CNT_WIDTH-1:0] instret
);

    state_t     state;
    state_t     next_state;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic [3:0] ula_op_dec;
    logic       retire;
    logic       illegal;

    logic       load_ir;
    logic       load_pc;
    logic       pc_next_sel;
    logic       pc_adder_sel;
    logic       din2_sel;
    logic [3:0] ula_op;
    logic [1:0] rf_sel;
    logic       we_rf;
    logic       we_mem;

    logic       unused_instr_bits;
    assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    ula_decoder u_ula_decoder (
        .opcode (opcode),
        .funct3 (funct3),
        .f7b5   (f7b5),
        .ula_op (ula_op_dec)
    );

    // Output and next-state decode from the state register and latched fields;
    // only branch PC selection and the MEMORY exit look at live inputs.
    always_comb begin
        next_state   = state;
        retire       = 1'b0;
        illegal      = 1'b0;
        load_ir      = 1'b0;
        load_pc      = 1'b0;
        pc_next_sel  = 1'b0;
        pc_adder_sel = 1'b0;
        din2_sel     = 1'b0;
        ula_op       = ULA_ADD;
        rf_sel       = RF_SEL_MEM;
        we_rf        = 1'b0;
        we_mem       = 1'b0;

        case (state)
            ST_FETCH: begin
                load_ir    = 1'b1;
                next_state = ST_DECODE;
            end

            ST_DECODE: begin
                case (opcode)
                    OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE:
                        next_state = ST_EXECUTE;
                    OPC_BRANCH:
                        if (funct3[2:1] == 2'b01) illegal = 1'b1;
                        else next_state = ST_EXECUTE;
                    OPC_AUIPC, OPC_JAL, OPC_JALR:
                        next_state = ST_WRITEBACK;
                    default:
                        illegal = 1'b1;
                endcase
                if (illegal) next_state = ST_FETCH;
            end

            ST_EXECUTE: begin
                ula_op   = ula_op_dec;
                din2_sel = (opcode != OPC_OP) && (opcode != OPC_BRANCH);
                case (opcode)
                    OPC_BRANCH: begin
                        load_pc      = 1'b1;
                        pc_adder_sel = 1'b1;
                        pc_next_sel  = branch_taken(funct3, bus.zero, bus.lt, bus.ltu);
                        retire       = 1'b1;
                        next_state   = ST_FETCH;
                    end
                    OPC_LOAD, OPC_STORE: next_state = ST_MEMORY;
                    default:             next_state = ST_WRITEBACK;
                endcase
            end

            ST_MEMORY: begin
                din2_sel = 1'b1;
                ula_op   = ula_op_dec;
                we_mem   = (opcode == OPC_STORE);
                if (bus.mem_ready) begin
                    if (opcode == OPC_STORE) begin
                        load_pc    = 1'b1;
                        retire     = 1'b1;
                        next_state = ST_FETCH;
                    end else begin
                        next_state = ST_WRITEBACK;
                    end
                end
            end

            ST_WRITEBACK: begin
                we_rf      = 1'b1;
                load_pc    = 1'b1;
                retire     = 1'b1;
                ula_op     = ula_op_dec;
                next_state = ST_FETCH;
                case (opcode)
                    OPC_OP:     rf_sel = RF_SEL_ALU;
                    OPC_OP_IMM: begin
                        rf_sel   = RF_SEL_ALU;
                        din2_sel = 1'b1;
                    end
                    OPC_AUIPC: begin
                        rf_sel       = RF_SEL_PCADD;
                        pc_adder_sel = 1'b1;
                    end
                    OPC_JAL: begin
                        rf_sel       = RF_SEL_PC4;
                        pc_adder_sel = 1'b1;
                        pc_next_sel  = 1'b1;
                    end
                    OPC_JALR: begin
                        rf_sel      = RF_SEL_PC4;
                        pc_next_sel = 1'b1;
                    end
                    default:    rf_sel = RF_SEL_MEM;
                endcase
            end

            default: next_state = ST_FETCH;
        endcase
    end

    // Architectural side effects are suppressed for the whole reset cycle.
    assign bus.load_ir      = load_ir && !reset;
    assign bus.load_pc      = load_pc && !reset;
    assign bus.WE_RF        = we_rf   && !reset;
    assign bus.WE_MEM       = we_mem  && !reset;
    assign bus.pc_next_sel  = pc_next_sel;
    assign bus.pc_adder_sel = pc_adder_sel;
    assign bus.ULA_din2_sel = din2_sel;
    assign bus.ula_op       = ula_op;
    assign bus.RF_din_sel   = rf_sel;
    assign illegal_instr    = illegal;
    assign state_o          = state;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= ST_FETCH;
            instret <= '0;
            opcode  <= '0;
            funct3  <= '0;
            f7b5    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_FETCH) begin
                opcode <= bus.instr[6:0];
                funct3 <= bus.instr[14:12];
                f7b5   <= bus.instr[30];
            end
            if (retire) instret <= instret + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc: walks each instruction class through the FSM
// and compares every cycle's controls against hand-derived values.
module tb_control_unit_mc;

    logic        CLK = 1'b0;
    logic        reset;
    logic        illegal_instr;
    logic [2:0]  state_o;
    logic [31:0] instret;
    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    int          c0;

    control_unit_mc_if bus();

    control_unit_mc #(.CNT_WIDTH(32)) dut (
        .CLK           (CLK),
        .reset         (reset),
        .bus           (bus),
        .illegal_instr (illegal_instr),
        .state_o       (state_o),
        .instret       (instret)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Present an instruction during FETCH and advance into DECODE.
    task automatic fetch(input string tag, input logic [31:0] iw);
        chk({tag, "_fetch_state"}, 32'(state_o), 0);
        chk({tag, "_load_ir"}, 32'(bus.load_ir), 1);
        bus.instr = iw;
        tick();
        bus.instr = 32'hFFFF_FFFF;
        chk({tag, "_dec_state"}, 32'(state_o), 1);
    endtask

    initial begin
        reset         = 1'b1;
        bus.instr     = '0;
        bus.zero      = 1'b0;
        bus.lt        = 1'b0;
        bus.ltu       = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        tick();
        chk("rst_state", 32'(state_o), 0);
        chk("rst_instret", instret, 0);
        chk("rst_load_ir", 32'(bus.load_ir), 0);
        chk("rst_we", 32'({bus.WE_RF, bus.WE_MEM, bus.load_pc}), 0);
        reset = 1'b0;
        #1;

        // add x3,x1,x2
        c0 = cyc;
        fetch("add", 32'h002081B3);
        chk("add_dec_illegal", 32'(illegal_instr), 0);
        tick();
        chk("add_ex_state", 32'(state_o), 2);
        chk("add_ex_din2", 32'(bus.ULA_din2_sel), 0);
        chk("add_ex_op", 32'(bus.ula_op), 0);
        chk("add_ex_load_pc", 32'(bus.load_pc), 0);
        tick();
        chk("add_wb_state", 32'(state_o), 4);
        chk("add_wb_we_rf", 32'(bus.WE_RF), 1);
        chk("add_wb_rfsel", 32'(bus.RF_din_sel), 1);
        chk("add_wb_op", 32'(bus.ula_op), 0);
        chk("add_wb_pc", 32'({bus.load_pc, bus.pc_next_sel}), 32'b10);
        chk("add_wb_instret", instret, 0);
        tick();
        chk("add_instret", instret, 1);
        chk("add_latency", 32'(cyc - c0), 4);

        // sub x3,x1,x2
        fetch("sub", 32'h402081B3);
        tick();
        chk("sub_ex_op", 32'(bus.ula_op), 1);
        tick();
        chk("sub_wb_rfsel", 32'(bus.RF_din_sel), 1);
        tick();
        chk("sub_instret", instret, 2);

        // srai x1,x1,3
        fetch("srai", 32'h4030D093);
        tick();
        chk("srai_ex_op", 32'(bus.ula_op), 7);
        chk("srai_ex_din2", 32'(bus.ULA_din2_sel), 1);
        tick();
        chk("srai_wb_din2_op", 32'({bus.ULA_din2_sel, bus.ula_op}), 32'h17);
        tick();
        chk("srai_instret", instret, 3);

        // lw x5,0(x1) with three wait cycles
        c0 = cyc;
        fetch("lw", 32'h0000A283);
        tick();
        chk("lw_ex_din2_op", 32'({bus.ULA_din2_sel, bus.ula_op}), 32'h10);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lw_wait_state", 32'(state_o), 3);
            chk("lw_wait_we", 32'({bus.WE_RF, bus.WE_MEM, bus.load_pc}), 0);
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("lw_mem_ready_state", 32'(state_o), 3);
        chk("lw_mem_ready_load_pc", 32'(bus.load_pc), 0);
        tick();
        bus.mem_ready = 1'b0;
        chk("lw_wb_state", 32'(state_o), 4);
        chk("lw_wb_rf", 32'({bus.WE_RF, bus.RF_din_sel}), 32'b100);
        tick();
        chk("lw_instret", instret, 4);
        chk("lw_latency", 32'(cyc - c0), 8);

        // sw x2,0(x1) with memory ready immediately
        c0 = cyc;
        bus.mem_ready = 1'b1;
        fetch("sw", 32'h0020A023);
        tick();
        chk("sw_ex_we_mem", 32'(bus.WE_MEM), 0);
        tick();
        chk("sw_mem_state", 32'(state_o), 3);
        chk("sw_mem_we", 32'({bus.WE_MEM, bus.WE_RF}), 32'b10);
        chk("sw_mem_pc", 32'({bus.load_pc, bus.pc_next_sel}), 32'b10);
        tick();
        bus.mem_ready = 1'b0;
        chk("sw_after_we_mem", 32'(bus.WE_MEM), 0);
        chk("sw_instret", instret, 5);
        chk("sw_latency", 32'(cyc - c0), 4);

        // beq taken, beq not taken, bgeu with ltu=1 (not taken)
        c0 = cyc;
        fetch("beq_t", 32'h00208063);
        tick();
        bus.zero = 1'b1;
        #1;
        chk("beq_t_ex", 32'({bus.load_pc, bus.pc_next_sel, bus.pc_adder_sel}), 32'b111);
        chk("beq_t_op", 32'({bus.ULA_din2_sel, bus.ula_op}), 32'h01);
        tick();
        chk("beq_t_instret", instret, 6);
        chk("beq_t_latency", 32'(cyc - c0), 3);
        bus.zero = 1'b0;
        fetch("beq_n", 32'h00208063);
        tick();
        chk("beq_n_ex", 32'({bus.load_pc, bus.pc_next_sel, bus.pc_adder_sel}), 32'b101);
        tick();
        chk("beq_n_instret", instret, 7);
        bus.ltu = 1'b1;
        fetch("bgeu", 32'h0020F063);
        tick();
        chk("bgeu_ex", 32'({bus.load_pc, bus.pc_next_sel}), 32'b10);
        tick();
        bus.ltu = 1'b0;

        // jal, jalr, auipc
        c0 = cyc;
        fetch("jal", 32'h000000EF);
        tick();
        chk("jal_wb_state", 32'(state_o), 4);
        chk("jal_wb", 32'({bus.RF_din_sel, bus.pc_next_sel, bus.pc_adder_sel, bus.WE_RF}), 32'b10111);
        tick();
        chk("jal_latency", 32'(cyc - c0), 3);
        fetch("jalr", 32'h000100E7);
        tick();
        chk("jalr_wb", 32'({bus.RF_din_sel, bus.pc_next_sel, bus.pc_adder_sel, bus.WE_RF}), 32'b10101);
        tick();
        fetch("auipc", 32'h00000297);
        tick();
        chk("auipc_wb", 32'({bus.RF_din_sel, bus.pc_next_sel, bus.pc_adder_sel, bus.load_pc}), 32'b11011);
        tick();
        chk("auipc_instret", instret, 11);

        // Illegal opcode and reserved branch funct3
        fetch("ill", 32'h0000007F);
        chk("ill_pulse", 32'(illegal_instr), 1);
        chk("ill_no_pc", 32'({bus.load_pc, bus.WE_RF}), 0);
        tick();
        chk("ill_state", 32'(state_o), 0);
        chk("ill_pulse_gone", 32'(illegal_instr), 0);
        chk("ill_instret", instret, 11);
        fetch("ill_br", 32'h0020A063);
        chk("ill_br_pulse", 32'(illegal_instr), 1);
        tick();
        chk("ill_br_instret", instret, 11);

        // Reset while a store waits in MEMORY
        fetch("sw_rst", 32'h0020A023);
        tick();
        tick();
        chk("sw_rst_mem_we", 32'({state_o, bus.WE_MEM}), 32'b0111);
        reset = 1'b1;
        #1;
        chk("sw_rst_we_forced", 32'(bus.WE_MEM), 0);
        tick();
        chk("sw_rst_state", 32'(state_o), 0);
        chk("sw_rst_instret", instret, 0);
        reset = 1'b0;
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/control_unit_mc.md
Name: control_unit_mc

Overview:
Multicycle control unit that drives the RISC-V datapath's control inputs: ULA_din2_sel, RF_din_sel, WE_RF, WE_MEM, load_pc, pc_next_sel and pc_adder_sel.
- Latches opcode/funct fields from the fetched instruction and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Resolves branches from ALU flags.
- Waits on a data-memory ready handshake.
- Counts retired instructions.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter instret.

Ports:
CLK  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
instr  in  32  instruction word from instruction memory; sampled only in FETCH.
zero  in  1  ALU result == 0.
lt  in  1  ALU signed less-than flag.
ltu  in  1  ALU unsigned less-than flag.
mem_ready  in  1  data memory done; meaningful only in MEMORY.
load_ir  out  1  datapath IR load enable.
load_pc  out  1  PC load enable.
pc_next_sel  out  1  0 = PC+4, 1 = PC-adder output.
pc_adder_sel  out  1  1 = PC+imm, 0 = rs1+imm.
ULA_din2_sel  out  1  0 = rs2, 1 = immediate.
ula_op  out  4  ALU operation code.
RF_din_sel  out  2  0 = memory, 1 = ALU, 2 = PC+4, 3 = PC-adder.
WE_RF  out  1  register-file write enable.
WE_MEM  out  1  data-memory write enable.
illegal_instr  out  1  one-cycle pulse in DECODE on an unsupported encoding.
state_o  out  3  current state, for debug.
instret  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- **Reset.** Synchronous, active-high. The CLK edge with reset=1 sets state to FETCH, clears instret and clears the latched fields.
  - While reset=1, WE_RF, WE_MEM, load_pc and load_ir are forced 0.
  - Reset mid-instruction aborts it: no write and no count.
- **Outputs.** Moore outputs: decoded from the state register and latched fields only.
  - Exceptions: branch load_pc/pc_next_sel depend on the flags; MEMORY exit depends on mem_ready.
  - Default for every output not listed below: 0.
- **State encoding.** FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4.
- **FETCH:**
  - load_ir=1.
  - Latch opcode=instr[6:0], funct3=instr[14:12], f7b5=instr[30].
  - Next state: DECODE.
- **DECODE** (next state by opcode):
  - OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011: EXECUTE.
  - AUIPC 0010111, JAL 1101111, JALR 1100111: WRITEBACK.
  - Any other opcode: illegal_instr=1, next FETCH. No PC update; PC holds.
  - BRANCH with funct3 010 or 011: illegal_instr=1, next FETCH.
- **EXECUTE:**
  - OP: ULA_din2_sel=0, ula_op from funct3/f7b5, next WRITEBACK.
  - OP-IMM: ULA_din2_sel=1, ula_op from funct3 (f7b5 used only for shifts), next WRITEBACK.
  - LOAD/STORE: ULA_din2_sel=1, ula_op=ADD, next MEMORY.
  - BRANCH: ULA_din2_sel=0, ula_op=SUB, load_pc=1, pc_adder_sel=1, next FETCH. This cycle retires the instruction.
  - Branch taken condition by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - Taken: pc_next_sel=1. Not taken: pc_next_sel=0.
- **MEMORY:**
  - ULA_din2_sel=1, ula_op=ADD held.
  - STORE: WE_MEM=1 while waiting.
  - Stays in MEMORY while mem_ready=0, with no timeout.
  - On mem_ready=1, LOAD goes to WRITEBACK.
  - On mem_ready=1, STORE goes to FETCH with load_pc=1, pc_next_sel=0; this cycle retires the instruction.
- **WRITEBACK:** WE_RF=1, load_pc=1, next FETCH; this cycle retires the instruction. Per opcode:
  - OP/OP-IMM: RF_din_sel=1, pc_next_sel=0, ALU controls held.
  - LOAD: RF_din_sel=0, pc_next_sel=0.
  - AUIPC: RF_din_sel=3, pc_adder_sel=1, pc_next_sel=0.
  - JAL: RF_din_sel=2, pc_adder_sel=1, pc_next_sel=1.
  - JALR: RF_din_sel=2, pc_adder_sel=0, pc_next_sel=1.
- **ALU op codes:** ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
  - SUB only for OP with funct3=000 and f7b5=1.
- **instret:** increments by 1 on each retiring edge; wraps from all-ones to 0. Illegal instructions do not count.
- **Instruction latency in cycles:** branch 3, jump/AUIPC 3, OP/OP-IMM 4, store 4+wait, load 5+wait.

Decomposition:
- Package control_pkg holds:
  - opcode localparams;
  - state encoding;
  - ula_op codes;
  - RF_din_sel encodings.
- One sub-module, ula_decoder: combinational mapping of opcode/funct3/f7b5 to ula_op.
- FSM, branch resolution and counter stay in control_unit_mc.

Test Plan:
1. add x3,x1,x2 (0x002081B3) → states 0,1,2,4. In WRITEBACK: WE_RF=1, RF_din_sel=1, ula_op=0, load_pc=1, pc_next_sel=0. instret goes 0→1.
2. ld (opcode 0000011) with mem_ready low for 3 MEMORY cycles → MEMORY held 4 cycles with WE_RF=0, then WRITEBACK with RF_din_sel=0. Total 8 cycles.
3. Store, mem_ready=1 immediately → WE_MEM=1 for exactly one cycle, WE_RF never 1, 4 cycles total.
4. beq with zero=1, then with zero=0 → EXECUTE shows load_pc=1 with pc_next_sel 1 (taken) and 0 (not taken). 3 cycles each.
5. jal, then jalr → WRITEBACK shows RF_din_sel=2, pc_next_sel=1, with pc_adder_sel 1 for jal and 0 for jalr. AUIPC shows RF_din_sel=3, pc_next_sel=0.
6. Opcode 0x7F → illegal_instr pulses in DECODE, instret unchanged. Separately, reset in MEMORY of a store → next state FETCH, WE_MEM=0, instret=0.
